subtrator_serial: RTL and testbench
===================================

// Module: subtrator_serial
// PURPOSE
//  Bit-serial signed subtractor: diferenca = num1 - num2, two's complement, LSB first, one bit per clock.
//  Inverse operation of the team's combinational 8-bit adder; reports the same flags (negativo, zero, par) plus overflow.
//  Trades latency for area.
//  Sits behind a start/done handshake so a controller can issue one operation at a time.
// PARAMETERS
//  N_BITS   8   operand/result width in bits (>= 2)
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       request; sampled only in IDLE
//  num1       in   N_BITS  signed minuend, sampled with start
//  num2       in   N_BITS  signed subtrahend, sampled with start
//  busy       out  1       high while in SHIFT
//  done       out  1       one-cycle pulse; result and flags valid from this cycle
//  diferenca  out  N_BITS  signed result, held until next completion
//  negativo   out  1       diferenca[N_BITS-1]; raw bit, not corrected for overflow
//  zero       out  1       diferenca == 0
//  par        out  1       ~diferenca[0]
//  overflow   out  1       signed overflow: carry into MSB != carry out of MSB
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, count=0; diferenca, negativo, zero, par, overflow, busy, done all 0.
//  Reset in mid-operation aborts the operation: no done, no partial result visible.
//  Outputs are registered; busy and done are decoded from state (Moore).
//  States:
//   IDLE  -> SHIFT on a clock edge with start=1.
//           Latch a=num1, b=~num2, carry=1, count=0.
//   SHIFT -> one bit per edge:
//           s = a[0]^b[0]^carry
//           carry = maj(a[0],b[0],carry)
//           shift s into a result shift register from the MSB side
//           a, b shift right; count++
//           On the edge with count==N_BITS-1 (last bit): record carry_in_msb and the final carry.
//           Load diferenca, flags and overflow in parallel on that edge, then go to DONE.
//   DONE  -> IDLE unconditionally on the next edge.
//  Latency: start sampled at edge E0. done is high in the cycle after edge E0+N_BITS (N_BITS edges later).
//  done lasts exactly one cycle.
//  Throughput: one operation per N_BITS+2 cycles. A new start is accepted only in IDLE.
//  start while busy or in DONE is ignored. It is not queued.
//  num1/num2 may change freely after the start edge; only the latched copies are used.
//  Flags and overflow update only on the DONE-entry edge. They hold their old values during SHIFT.
//  Wrap-around: the result is modulo 2^N_BITS; overflow flags a signed overflow.
//  Example: -128 - 1 = +127 with overflow=1.
//  Subtracting the minimum value (num2 = -2^(N_BITS-1)) is handled by the ~num2 + 1 path. No special case.
// TESTING
//  T1 num1=5, num2=3, start 1 cycle -> done exactly 8 edges later.
//     diferenca=2, negativo=0, zero=0, par=1, overflow=0.
//  T2 num1=7, num2=7 -> diferenca=0, zero=1, par=1, negativo=0, overflow=0.
//  T3 num1=-5 (0xFB), num2=3 -> diferenca=-8 (0xF8), negativo=1, par=1, zero=0, overflow=0.
//  T4 num1=-128 (0x80), num2=1 -> diferenca=127 (0x7F), overflow=1, negativo=0, par=0.
//     Also: num1=0, num2=-128 -> diferenca=0x80, overflow=1.
//  T5 start held high continuously, operands changed every cycle:
//     each result matches the operands latched in IDLE; done pulses every 10 cycles.
//     Outputs are stable between pulses.
//  T6 assert reset 4 cycles into an operation:
//     all outputs 0 immediately (asynchronous), no done pulse.
//     A fresh start after deassert gives the correct result.

Source files
------------

// File: rtl/subtrator_serial.sv
// ============================================================================
//  Module   : subtrator_serial
//  Purpose  : Bit-serial two's-complement subtractor (num1 - num2), LSB first,
//             one bit per clock, behind a start/done handshake. Reports
//             negativo, zero, par and signed overflow with the result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtrator_serial #(
    parameter int N_BITS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] num1,
    input  logic [N_BITS-1:0] num2,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] diferenca,
    output logic              negativo,
    output logic              zero,
    output logic              par,
    output logic              overflow
);

    localparam int CW = (N_BITS > 2) ? $clog2(N_BITS) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [CW-1:0] c_LAST = CW'(N_BITS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;

    // Latched operands: minuend and inverted subtrahend (the +1 comes in as carry)
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic              r_carry;
    logic [CW-1:0]     r_count;
    logic [N_BITS-1:0] r_sr;

    logic              w_s;
    logic              w_cout;
    logic              w_last;
    logic [N_BITS-1:0] w_res;

    // One full-adder slice on the current LSBs; the result enters from the MSB side
    always_comb begin
        w_s    = r_a[0] ^ r_b[0] ^ r_carry;
        w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_last = (r_count == c_LAST);
        w_res  = {w_s, r_sr[N_BITS-1:1]};
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: DONE always returns to IDLE, so a start there is dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_next = c_SHIFT;
            c_SHIFT: if (w_last) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Moore handshake outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_SHIFT: busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath; visible result and flags change only on the last bit edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_count   <= '0;
            r_sr      <= '0;
            diferenca <= '0;
            negativo  <= 1'b0;
            zero      <= 1'b0;
            par       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= num1;
                        r_b     <= ~num2;
                        r_carry <= 1'b1;
                        r_count <= '0;
                    end
                end
                c_SHIFT: begin
                    r_sr    <= w_res;
                    r_a     <= {1'b0, r_a[N_BITS-1:1]};
                    r_b     <= {1'b0, r_b[N_BITS-1:1]};
                    r_carry <= w_cout;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        diferenca <= w_res;
                        negativo  <= w_s;
                        zero      <= (w_res == '0);
                        par       <= ~w_res[0];
                        // r_carry is the carry into the MSB slice, w_cout the carry out of it
                        overflow  <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subtrator_serial.sv
// ============================================================================
//  Module   : tb_subtrator_serial
//  Purpose  : Directed self-checking bench for subtrator_serial (N_BITS = 8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtrator_serial;

    localparam int N_BITS = 8;

    logic              clock;
    logic              reset;
    logic              start;
    logic [N_BITS-1:0] num1;
    logic [N_BITS-1:0] num2;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] diferenca;
    logic              negativo;
    logic              zero;
    logic              par;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N_BITS-1:0] prev_d = '0;

    subtrator_serial #(.N_BITS(N_BITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num1      (num1),
        .num2      (num2),
        .busy      (busy),
        .done      (done),
        .diferenca (diferenca),
        .negativo  (negativo),
        .zero      (zero),
        .par       (par),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference subtraction: {overflow, difference}
    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        return {(a[7] != b[7]) && (d[7] != a[7]), d};
    endfunction

    // One operation with hand-computed expectations; leaves the DUT back in IDLE
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic en, input logic ez,
                          input logic ep, input logic eo);
        int lat;
        bit got;
        @(negedge clock);
        start = 1'b1; num1 = a; num2 = b;
        @(posedge clock); #1;
        start = 1'b0; num1 = ~a; num2 = a ^ 8'h5A;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 4) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_hold"}, 32'(diferenca), 32'(prev_d));
            end
            if (done) got = 1;
        end
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_dif"}, 32'(diferenca), 32'(ed));
        check({tag, "_flags"}, {28'd0, negativo, zero, par, overflow}, {28'd0, en, ez, ep, eo});
        @(posedge clock); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        prev_d = ed;
    endtask

    initial begin : main
        logic [7:0] op1 [0:2];
        logic [7:0] op2 [0:2];
        logic [8:0] r;
        logic [7:0] last_d;
        int seen;

        reset = 1'b1; start = 1'b0; num1 = '0; num2 = '0;
        #12;
        check("reset_outs", {22'd0, busy, done, diferenca}, 32'd0);
        check("reset_flags", {28'd0, negativo, zero, par, overflow}, 32'd0);
        @(negedge clock); reset = 1'b0;

        // T1..T4
        run_op("t1", 8'd5,   8'd3,   8'd2,   1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t2", 8'd7,   8'd7,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0);
        run_op("t3", 8'hFB,  8'd3,   8'hF8,  1'b1, 1'b0, 1'b1, 1'b0);
        run_op("t4a", 8'h80, 8'd1,   8'h7F,  1'b0, 1'b0, 1'b0, 1'b1);
        run_op("t4b", 8'h00, 8'h80,  8'h80,  1'b1, 1'b0, 1'b1, 1'b1);
        run_op("t4c", 8'h7F, 8'hFF,  8'h80,  1'b1, 1'b0, 1'b1, 1'b1);

        // T5: start held high, operands changing every cycle
        last_d = prev_d;
        seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            start = 1'b1;
            num1 = 8'(cyc * 37 + 11);
            num2 = 8'(cyc * 91 + 200);
            if (cyc % 10 == 0) begin
                op1[cyc / 10] = num1;
                op2[cyc / 10] = num2;
            end
            @(posedge clock); #1;
            check("t5_done", 32'(done), 32'((cyc % 10) == 8));
            if (done && (cyc % 10) == 8) begin
                r = ref_sub(op1[cyc / 10], op2[cyc / 10]);
                check("t5_dif", 32'(diferenca), 32'(r[7:0]));
                check("t5_ovf", 32'(overflow), 32'(r[8]));
                last_d = r[7:0];
                seen++;
            end else begin
                check("t5_stable", 32'(diferenca), 32'(last_d));
            end
        end
        check("t5_count", seen, 32'd3);
        @(negedge clock); start = 1'b0;
        @(posedge clock); #1;
        prev_d = last_d;

        // Ensure a nonzero result is on the outputs before the abort
        run_op("t6pre", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);

        // T6: asynchronous reset four edges into an operation
        @(negedge clock);
        start = 1'b1; num1 = 8'd50; num2 = 8'd20;
        @(posedge clock); #1; start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_async_dif", 32'(diferenca), 32'd0);
        check("t6_async_ctl", {30'd0, busy, done}, 32'd0);
        check("t6_async_flags", {28'd0, negativo, zero, par, overflow}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        check("t6_no_done", seen, 32'd0);
        prev_d = '0;
        run_op("t6post", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
